inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer in front of the direct-mapped instruction cache. Owns the fetch PC,
//  looks up the cache every cycle, services misses by requesting one 32-bit word from the memory
//  controller and writing it into the cache, and delivers (pc, instruction) pairs to the decoder
//  through a valid/ready slot. Handles branch/jump redirects (flush) from the back end.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC after reset
//  PC_STEP    4              PC increment per delivered instruction
// PORTS
//  clk_in          in   1   system clock; all state updates on posedge
//  rst_in          in   1   synchronous, active-high reset
//  rdy_in          in   1   global ready; when low, no register changes (full freeze)
//  flush_in        in   1   redirect request; highest priority
//  flush_pc        in   32  redirect target; bits [1:0] ignored (forced 00)
//  ic_addr         out  32  cache lookup address = current PC (combinational from PC reg)
//  ic_hit          in   1   cache hit for ic_addr (combinational, same cycle)
//  ic_data         in   32  cache data for ic_addr
//  ic_update       out  1   cache write strobe, one-cycle pulse
//  ic_update_addr  out  32  cache write address
//  ic_update_data  out  32  cache write data
//  mem_req         out  1   word-fetch request, level, held until mem_ack
//  mem_addr        out  32  word-fetch address, stable while mem_req=1
//  mem_ack         in   1   one-cycle pulse: mem_data valid, request complete
//  mem_data        in   32  fetched word
//  inst_valid      out  1   output slot holds an instruction
//  inst_out        out  32  instruction
//  inst_pc         out  32  PC of inst_out
//  inst_ready      in   1   decoder accepts slot this cycle (transfer = inst_valid & inst_ready)
// BEHAVIOUR
//  Reset: state=LOOKUP, pc=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, mem_req=0, mem_addr=0,
//   ic_update=0, ic_update_addr=0, ic_update_data=0, flush_pend=0. Reset overrides rdy_in.
//  rdy_in=0: every register holds; mem_ack/flush_in not sampled. Outputs hold their values.
//  slot_free = !inst_valid | inst_ready.
//  States: LOOKUP, WAIT, REFILL.
//  LOOKUP: if ic_hit & slot_free -> inst_out<=ic_data, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_STEP
//   (hit throughput 1 instr/cycle). If ic_hit & !slot_free -> hold everything. If !ic_hit ->
//   mem_req<=1, mem_addr<=pc, ->WAIT (slot content unaffected; may still drain via inst_ready).
//  WAIT: mem_req held. On mem_ack: mem_req<=0, ic_update<=1, ic_update_addr<=mem_addr,
//   ic_update_data<=mem_data, ->REFILL.
//  REFILL: ic_update=1 for exactly this cycle; ic_update<=0, flush_pend<=0, ->LOOKUP.
//   Next LOOKUP hits unless redirected. Miss penalty = mem latency + 2 cycles.
//  Any state, inst_valid & inst_ready with no load this cycle -> inst_valid<=0.
//  flush_in=1 (priority over hit/transfer): pc<=flush_pc&~3, inst_valid<=0 (slot dropped even if
//   inst_ready=1 same cycle; no hit loaded that cycle).
//   LOOKUP: stay LOOKUP, no mem_req issued that cycle.
//   WAIT: outstanding request not aborted; mem_req/mem_addr held, flush_pend<=1; refill still
//    written to cache with old address; the fetched word is never delivered.
//   REFILL: refill completes; then LOOKUP at new pc.
//  flush_in coincident with mem_ack in WAIT: both apply (refill old addr, pc=new target).
//  PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
//  Invariant: mem_req never drops before mem_ack; at most one outstanding request.
// TESTING
//  Cold miss: reset, RESET_PC=0, ack 3 cycles after req with 32'h0050_0093 -> mem_req=1/mem_addr=0
//   cycle 1, ic_update pulse addr 0 data 32'h0050_0093, then inst_valid=1, inst_pc=0, inst_out=32'h0050_0093.
//  Hit stream: cache model preloaded at 0,4,8, inst_ready=1 -> inst_valid three consecutive cycles,
//   inst_pc 0,4,8; mem_req stays 0.
//  Backpressure: inst_ready=0 for 4 cycles with hits -> inst_out/inst_pc stable, ic_addr stable;
//   ready=1 -> next pc delivered next cycle.
//  Flush in WAIT: miss at 0x40, flush_pc=0x103 while waiting -> mem_req held until ack, ic_update
//   addr 0x40, no delivery of 0x40, next mem_req/ic_addr = 0x100.
//  Flush vs transfer: inst_valid=1, inst_ready=1, flush_pc=0x200 same cycle -> inst_valid=0 next
//   cycle, next delivered inst_pc=0x200.
//  Freeze/wrap: rdy_in=0 for 5 cycles in WAIT with mem_ack pulsed -> no state change; hit at
//   pc=32'hFFFF_FFFC -> next ic_addr=0.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction-fetch sequencer in front of a direct-mapped I-cache
//
// Purpose: owns the fetch PC. The cache is looked up every cycle, and a miss is serviced with a
// single-word memory request whose result is written back into the cache. Instructions go to the
// decoder through a one-entry valid/ready slot. A flush from the back end redirects the PC.
//
// Ports:
//   clk_in, rst_in, rdy_in          clock, synchronous active-high reset, global freeze (low = hold)
//   flush_in, flush_pc              redirect request and target (low two bits forced to zero)
//   ic_addr / ic_hit, ic_data       cache lookup address (current PC) and same-cycle hit/data
//   ic_update, ic_update_addr/data  one-cycle cache write strobe with address and data
//   mem_req, mem_addr / mem_ack,    word-fetch request held until acknowledged, then ack pulse
//   mem_data                          with the returned word
//   inst_valid, inst_out, inst_pc   decoder slot contents
//   inst_ready                      decoder takes the slot this cycle

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_data,
  output logic        ic_update,
  output logic [31:0] ic_update_addr,
  output logic [31:0] ic_update_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {ST_LOOKUP, ST_WAIT, ST_REFILL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_inst_valid;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_ic_update;
  logic [31:0] r_ic_update_addr;
  logic [31:0] r_ic_update_data;

  logic        w_slot_free;
  logic [31:0] w_flush_tgt;

  // The slot can take a new instruction when it is empty or being drained this same cycle.
  assign w_slot_free = !r_inst_valid || inst_ready;
  assign w_flush_tgt = flush_pc & ~32'h3;

  assign ic_addr        = r_pc;
  assign ic_update      = r_ic_update;
  assign ic_update_addr = r_ic_update_addr;
  assign ic_update_data = r_ic_update_data;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign inst_valid     = r_inst_valid;
  assign inst_out       = r_inst_out;
  assign inst_pc        = r_inst_pc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= ST_LOOKUP;
      r_pc             <= RESET_PC;
      r_inst_valid     <= 1'b0;
      r_inst_out       <= 32'h0;
      r_inst_pc        <= 32'h0;
      r_mem_req        <= 1'b0;
      r_mem_addr       <= 32'h0;
      r_ic_update      <= 1'b0;
      r_ic_update_addr <= 32'h0;
      r_ic_update_data <= 32'h0;
    end else if (rdy_in) begin
      // Drain first; a load below overrides this when a new instruction enters the slot.
      if (r_inst_valid && inst_ready) begin
        r_inst_valid <= 1'b0;
      end

      case (r_state)
        ST_LOOKUP: begin
          // A redirect suppresses both the hit load and the miss request for this cycle.
          if (!flush_in) begin
            if (ic_hit) begin
              if (w_slot_free) begin
                r_inst_out   <= ic_data;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= r_pc + PC_STEP;
              end
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_pc;
              r_state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // The request is never abandoned; a flush while waiting only moves the PC, so the
          // refilled word lands in the cache but the next lookup happens at the new target.
          if (mem_ack) begin
            r_mem_req        <= 1'b0;
            r_ic_update      <= 1'b1;
            r_ic_update_addr <= r_mem_addr;
            r_ic_update_data <= mem_data;
            r_state          <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          r_ic_update <= 1'b0;
          r_state     <= ST_LOOKUP;
        end
        default: begin
          r_state <= ST_LOOKUP;
        end
      endcase

      // Redirect wins over any load or drain made above.
      if (flush_in) begin
        r_pc         <= w_flush_tgt;
        r_inst_valid <= 1'b0;
      end
    end
  end

endmodule
